// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// states and the source-ID width.
package intc_pkg;

    localparam logic [1:0] INTC_OFS_PEND = 2'd0;
    localparam logic [1:0] INTC_OFS_MASK = 2'd1;
    localparam logic [1:0] INTC_OFS_ID   = 2'd2;
    localparam logic [1:0] INTC_OFS_CLR  = 2'd3;

    localparam int INTC_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Picks one eligible source. Fixed lowest-index priority by default; with
// INTC_ROTATE_PRIORITY_EN defined the search starts at start_i and wraps.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NumSources = 4
) (
    input  logic [NumSources-1:0] elig_i,
    input  logic [INTC_ID_W-1:0]  start_i,
    output logic [INTC_ID_W-1:0]  id_o,
    output logic                  valid_o
);

`ifdef INTC_ROTATE_PRIORITY_EN
    logic [NumSources-1:0] rot;

    // Rotate so that bit 0 of rot is the source at start_i, then take the
    // lowest set bit and map it back to an absolute ID.
    always_comb begin
        rot     = NumSources'({elig_i, elig_i} >> start_i);
        id_o    = '0;
        valid_o = 1'b0;
        for (int k = NumSources - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                id_o    = INTC_ID_W'((int'(start_i) + k) % NumSources);
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start_i;

    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                valid_o = 1'b1;
                id_o    = INTC_ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing interrupt controller with mask/status registers on the 8-bit
// bus and a raise/ack handshake to the CPU. INTC_ROTATE_PRIORITY_EN selects round-robin.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter logic [7:0] IntcBaseAddr = 8'hE0,
    parameter int         NumSources   = 4,
    parameter logic [7:0] InitialMask  = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    input  logic [NumSources-1:0] SRC_RAISE,
    output logic [NumSources-1:0] SRC_ACK,
    output logic                  CPU_INTERRUPT_RAISE,
    input  logic                  CPU_INTERRUPT_ACK
);

    logic [NumSources-1:0] src_sync_q, src_prev_q;
    logic [NumSources-1:0] pending_q, pending_d, mask_q, mask_d;
    logic [NumSources-1:0] rise, eligible, wr_clr, ack_clr, active_oh;
    intc_state_e           state_q;
    logic [INTC_ID_W-1:0]  active_id_q, sel_id, start_ptr;
    logic                  sel_valid, raise_q, req_ack;
    logic [NumSources-1:0] src_ack_q;
    logic [7:0]            ofs, rd_data;
    logic                  hit, rd_en_q;
    logic [1:0]            rd_ofs_q;
    logic                  unused_bus;

    assign unused_bus = ^BUS_DATA;
    assign ofs        = BUS_ADDR - IntcBaseAddr;
    assign hit        = (ofs < 8'd4);

    assign mask_d = (hit && BUS_WE && ofs[1:0] == INTC_OFS_MASK)
                    ? BUS_DATA[NumSources-1:0] : mask_q;
    assign wr_clr = (hit && BUS_WE && ofs[1:0] == INTC_OFS_CLR)
                    ? BUS_DATA[NumSources-1:0] : '0;

    // Edge detect on the sampled level; a set in the same cycle as a clear wins.
    assign rise      = src_sync_q & ~src_prev_q;
    assign active_oh = NumSources'(1) << active_id_q;
    assign req_ack   = (state_q == REQ) && CPU_INTERRUPT_ACK;
    assign ack_clr   = req_ack ? active_oh : '0;
    assign pending_d = (pending_q & ~(wr_clr | ack_clr)) | rise;
    assign eligible  = pending_q & mask_q;

    intc_prio_enc #(.NumSources(NumSources)) u_prio_enc (
        .elig_i  (eligible),
        .start_i (start_ptr),
        .id_o    (sel_id),
        .valid_o (sel_valid)
    );

`ifdef INTC_ROTATE_PRIORITY_EN
    logic [INTC_ID_W-1:0] last_q;
    assign start_ptr = (last_q == INTC_ID_W'(NumSources - 1)) ? '0 : last_q + 1'b1;
`else
    assign start_ptr = '0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            src_sync_q <= '0;
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= InitialMask[NumSources-1:0];
            rd_en_q    <= 1'b0;
            rd_ofs_q   <= '0;
        end else begin
            src_sync_q <= SRC_RAISE;
            src_prev_q <= src_sync_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            rd_en_q    <= hit && !BUS_WE;
            rd_ofs_q   <= ofs[1:0];
        end
    end

    // active_id_q only moves on the IDLE->REQ transition, so an outstanding
    // request is never pre-empted.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            active_id_q <= '0;
            raise_q     <= 1'b0;
            src_ack_q   <= '0;
`ifdef INTC_ROTATE_PRIORITY_EN
            last_q      <= INTC_ID_W'(NumSources - 1);
`endif
        end else begin
            src_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        active_id_q <= sel_id;
                        raise_q     <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (CPU_INTERRUPT_ACK) begin
                        raise_q   <= 1'b0;
                        src_ack_q <= active_oh;
                        state_q   <= ACK;
`ifdef INTC_ROTATE_PRIORITY_EN
                        last_q    <= active_id_q;
`endif
                    end else if ((pending_q & active_oh) == '0) begin
                        raise_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_ofs_q)
            INTC_OFS_PEND: rd_data = 8'(pending_q);
            INTC_OFS_MASK: rd_data = 8'(mask_q);
            INTC_OFS_ID:   rd_data = {state_q != IDLE, 4'b0000, active_id_q};
            default:       rd_data = '0;
        endcase
    end

    assign BUS_DATA            = rd_en_q ? rd_data : 'z;
    assign SRC_ACK             = src_ack_q;
    assign CPU_INTERRUPT_RAISE = raise_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects interrupt-raise levels from bus peripherals (timer, keyboard, mouse, …) and latches them as pending on their rising edge. It selects one pending, unmasked source by priority and presents a single raise/ack pair to the processor. On the processor's acknowledge it returns a one-cycle acknowledge to the selected peripheral. Sits between the peripherals' BUS_INTERRUPT_RAISE/ACK pins and the processor's interrupt input, and exposes mask/status registers on the shared 8-bit bus.

## Interface
- Parameters:
  - `IntcBaseAddr`, default 8'hE0, base of the 4-byte register window.
  - `NumSources`, default 4, number of peripheral sources (1–8).
  - `InitialMask`, default 8'hFF, reset value of the enable mask (1 = enabled).
- Ports:
  - `CLK`, in, 1, system clock (100 MHz).
  - `RESET`, in, 1, asynchronous, active-low reset.
  - `BUS_DATA`, inout, 8, shared tristate data bus.
  - `BUS_ADDR`, in, 8, bus address.
  - `BUS_WE`, in, 1, bus write enable.
  - `SRC_RAISE`, in, NumSources, per-peripheral interrupt-raise levels; index 0 is the timer.
  - `SRC_ACK`, out, NumSources, per-peripheral acknowledge pulses.
  - `CPU_INTERRUPT_RAISE`, out, 1, request to the processor.
  - `CPU_INTERRUPT_ACK`, in, 1, processor acknowledge.

## Operation
- Register map:
  - Base+0 (R): pending vector.
  - Base+1 (R/W): mask.
  - Base+2 (R): active source ID; bit 7 = valid.
  - Base+3 (W): write-1-to-clear pending bits.
- Edge capture:
  - `SRC_RAISE` is registered once.
  - A 0→1 transition sets `pending[i]`.
  - A held-high level does not re-set the bit after it is cleared.
- Clearing a pending bit:
  - Write-1-clear at Base+3, or acknowledge of that source.
  - If a set and a clear of the same bit occur in the same cycle, set wins.
- Eligible vector = pending & mask.
  - Masking does not clear pending.
  - Unmasking a pending source makes it eligible on the next cycle.
- Selection: fixed priority, lowest index wins (rotating priority under the macro in Configuration).
- FSM, 3 states:
  - IDLE: if the eligible vector is non-zero, latch the selected ID into `active_id` and go to REQ.
  - REQ: `CPU_INTERRUPT_RAISE`=1.
    - On `CPU_INTERRUPT_ACK`=1: clear `pending[active_id]` and go to ACK.
    - If `pending[active_id]` is cleared by software while in REQ: drop the raise and return to IDLE without pulsing `SRC_ACK`.
  - ACK: `SRC_ACK[active_id]`=1 for exactly one cycle, then go to IDLE.
- `active_id` is frozen outside IDLE; a higher-priority arrival does not pre-empt an outstanding request.
- Pending, mask and ID registers are `NumSources` bits wide, zero-extended to 8 bits on read. Writes to unimplemented mask bits are ignored.

## Timing
- Reset values:
  - `CPU_INTERRUPT_RAISE`=0, `SRC_ACK`=0.
  - pending=0, mask=`InitialMask`, FSM=IDLE.
  - Source edge registers = 0, so a source already high at reset release registers an edge.
  - `BUS_DATA` = high-Z.
- Source edge to `CPU_INTERRUPT_RAISE`: 3 cycles from the edge at the `SRC_RAISE` pin with the FSM in IDLE (sample register, pending set, IDLE→REQ).
- `CPU_INTERRUPT_ACK` sampled in REQ → `SRC_ACK` high on the next cycle, for one cycle; the raise drops in the same cycle `SRC_ACK` rises.
- Minimum gap between consecutive CPU requests: 1 IDLE cycle.
- Bus reads use a registered drive enable: `BUS_DATA` is driven during the cycle after `BUS_ADDR` matches. Read data reflects register contents at that cycle.
- `CPU_INTERRUPT_ACK` outside REQ is ignored.
- Reset asserted mid-handshake: all state returns to reset values immediately; no `SRC_ACK` pulse is emitted.

## Configuration
- `INTC_ROTATE_PRIORITY_EN`:
  - Defined: round-robin selection. Search starts at (last served ID + 1) mod `NumSources`, so a continuously re-raising source cannot starve others. The last-served pointer resets to `NumSources`-1, making the first grant fixed-priority.
  - Undefined: fixed lowest-index priority; no pointer register.

## Structure
- Shared package `intc_pkg`:
  - Register offsets: `INTC_OFS_PEND`=0, `INTC_OFS_MASK`=1, `INTC_OFS_ID`=2, `INTC_OFS_CLR`=3.
  - FSM state typedef {IDLE, REQ, ACK}.
  - ID width constant (3).
- One sub-module, `intc_prio_enc`:
  - Combinational.
  - Inputs: eligible vector and start pointer.
  - Outputs: ID and valid.
  - Rotation logic sits inside it, guarded by the macro.

## Test plan
- Single source: pulse `SRC_RAISE[0]` high, hold 10 cycles → raise asserted 3 cycles after the edge; assert ack → `SRC_ACK`=4'b0001 for 1 cycle; pending reads 8'h00.
- Priority: edges on sources 2 and 1 in the same cycle → ID reads 8'h81 first. After ack → ID 8'h82 on the next request. Under the macro, same stimulus with last served = 1 → source 2 first.
- Masking: write 8'hFE to E1, edge on source 0 → no raise, pending reads 8'h01; write 8'hFF → raise within 2 cycles.
- Software clear: in REQ for source 3, write 8'h08 to E3 → raise drops, no `SRC_ACK`, FSM back to IDLE.
- Held level: `SRC_RAISE[0]` held high across ack → exactly one request; a second request only after a 0→1 re-edge.
- Async reset in ACK state → `SRC_ACK` and raise go to 0 without a clock; mask reads 8'h0F afterwards (`NumSources`=4).
